// File: rtl/nucleic_acid_pkg.sv
// Shared types and constants for the nucleic-acid extraction sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nucleic_acid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_LYSE    = 3'd2,
        ST_MIX     = 3'd3,
        ST_TRAP    = 3'd4,
        ST_WASH    = 3'd5,
        ST_ELUTE   = 3'd6,
        ST_COLLECT = 3'd7
    } state_e;

    // Bit positions inside the packed valve vector.
    localparam int V_LYSIS      = 9;
    localparam int V_WASH       = 8;
    localparam int V_ELUTE      = 7;
    localparam int V_HORIZ      = 6;
    localparam int V_VERTICAL   = 5;
    localparam int V_DEAD_END   = 4;
    localparam int V_LOOP_EXIT  = 3;
    localparam int V_BEAD_VTL   = 2;
    localparam int V_BEAD_TRAP  = 1;
    localparam int V_COLLECTION = 0;

    // {pump1,pump2,pump3} per phase; entry [0] is the first phase of a stroke.
    localparam logic [5:0][2:0] PUMP_PATTERN = {
        3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011
    };
    localparam logic [2:0] PUMP_IDLE = 3'b111;

    // Valves open (1 = open, i.e. control driven 0) per state, indexed by state code.
    localparam logic [7:0][9:0] VALVE_OPEN = {
        10'b0000001011,   // COLLECT: loop_exit, bead_trap, collection
        10'b0010100000,   // ELUTE:   elute, vertical
        10'b0100100000,   // WASH:    wash, vertical
        10'b0100001100,   // TRAP:    wash, loop_exit, bead_vtl
        10'b0000000000,   // MIX:     ring closed
        10'b1000100000,   // LYSE:    lysis, vertical
        10'b0001000000,   // FILL:    horiz
        10'b0000000000    // IDLE:    all closed
    };

    function automatic logic is_pumped(input state_e s);
        return (s == ST_LYSE) || (s == ST_MIX) || (s == ST_WASH) || (s == ST_ELUTE);
    endfunction

endpackage

// File: rtl/nucleic_acid_ctrl_pump.sv
// Three-phase peristaltic pump pattern generator with phase timer and stroke counter.
// Latency: pump output registered from next-phase; first phase appears the edge run rises.
// Backpressure: none; run=0 forces 111 and clears all counters.
module peristaltic_pump_drv
    import nucleic_acid_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int STROKE_W     = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [STROKE_W-1:0] strokes,
    output logic [2:0]          pump,
    output logic                stroke_done
);

    localparam int PCW = $clog2(PHASE_CYCLES + 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PHASE_CYCLES - 1);

    logic                active_q,     active_d;
    logic [PCW-1:0]      phase_cnt_q,  phase_cnt_d;
    logic [2:0]          phase_idx_q,  phase_idx_d;
    logic [STROKE_W-1:0] stroke_cnt_q, stroke_cnt_d;
    logic [2:0]          pump_q,       pump_d;
    logic                last_cycle;

    // Advance phase/stroke counters; restart at phase 0 on entry or after the final cycle.
    always_comb begin
        last_cycle   = active_q && (phase_cnt_q == PC_LAST) && (phase_idx_q == 3'd5)
                       && (stroke_cnt_q == strokes - STROKE_W'(1));
        active_d     = run;
        phase_cnt_d  = '0;
        phase_idx_d  = '0;
        stroke_cnt_d = '0;
        pump_d       = PUMP_IDLE;
        if (run) begin
            if (active_q && !last_cycle) begin
                phase_cnt_d  = phase_cnt_q;
                phase_idx_d  = phase_idx_q;
                stroke_cnt_d = stroke_cnt_q;
                if (phase_cnt_q == PC_LAST) begin
                    phase_cnt_d = '0;
                    if (phase_idx_q == 3'd5) begin
                        phase_idx_d  = '0;
                        stroke_cnt_d = stroke_cnt_q + STROKE_W'(1);
                    end else begin
                        phase_idx_d = phase_idx_q + 3'd1;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + PCW'(1);
                end
            end
            pump_d = PUMP_PATTERN[phase_idx_d];
        end
    end

    // Counter and pump output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            phase_cnt_q  <= '0;
            phase_idx_q  <= '0;
            stroke_cnt_q <= '0;
            pump_q       <= PUMP_IDLE;
        end else begin
            active_q     <= active_d;
            phase_cnt_q  <= phase_cnt_d;
            phase_idx_q  <= phase_idx_d;
            stroke_cnt_q <= stroke_cnt_d;
            pump_q       <= pump_d;
        end
    end

    assign pump        = pump_q;
    assign stroke_done = last_cycle;

endmodule

// File: rtl/nucleic_acid_ctrl.sv
// Extraction-run sequencer: FSM, cycle timer and registered valve/pump outputs.
// Latency: every output registered from next-state; changes on the same edge as state.
// Backpressure: none; start sampled only in IDLE, abort forces IDLE on the next edge.
module nucleic_acid_ctrl
    import nucleic_acid_pkg::*;
#(
    parameter int PHASE_CYCLES   = 4,
    parameter int FILL_CYCLES    = 16,
    parameter int LYSE_STROKES   = 8,
    parameter int MIX_STROKES    = 32,
    parameter int WASH_STROKES   = 8,
    parameter int ELUTE_STROKES  = 8,
    parameter int COLLECT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       lysis_ctl,
    output logic       wash_ctl,
    output logic       elute_ctl,
    output logic       horiz_ctl,
    output logic       vertical_ctl,
    output logic       dead_end_ctl,
    output logic       loop_exit_ctl,
    output logic       bead_vtl_ctl,
    output logic       bead_trap_ctl,
    output logic       collection_ctl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    localparam int MAX_TIMED  = (FILL_CYCLES > COLLECT_CYCLES) ? FILL_CYCLES : COLLECT_CYCLES;
    localparam int CYC_W      = $clog2(MAX_TIMED + 1);
    localparam int MAX_S1     = (LYSE_STROKES > MIX_STROKES) ? LYSE_STROKES : MIX_STROKES;
    localparam int MAX_S2     = (WASH_STROKES > ELUTE_STROKES) ? WASH_STROKES : ELUTE_STROKES;
    localparam int MAX_STROKE = (MAX_S1 > MAX_S2) ? MAX_S1 : MAX_S2;
    localparam int STROKE_W   = $clog2(MAX_STROKE + 1);

    state_e              state_q, state_d;
    logic [CYC_W-1:0]    cyc_q,   cyc_d;
    logic [9:0]          valve_q, valve_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    logic                cyc_last;
    logic                timed;
    logic [STROKE_W-1:0] strokes_sel;
    logic                stroke_done;
    logic [2:0]          pump_vec;

    // Per-state duration selection: cycle budget for timed states, stroke count for pumped ones.
    always_comb begin
        cyc_last    = 1'b0;
        timed       = 1'b0;
        strokes_sel = '0;
        unique case (state_q)
            ST_FILL, ST_TRAP: begin
                timed    = 1'b1;
                cyc_last = (cyc_q == CYC_W'(FILL_CYCLES - 1));
            end
            ST_COLLECT: begin
                timed    = 1'b1;
                cyc_last = (cyc_q == CYC_W'(COLLECT_CYCLES - 1));
            end
            ST_LYSE:  strokes_sel = STROKE_W'(LYSE_STROKES);
            ST_MIX:   strokes_sel = STROKE_W'(MIX_STROKES);
            ST_WASH:  strokes_sel = STROKE_W'(WASH_STROKES);
            ST_ELUTE: strokes_sel = STROKE_W'(ELUTE_STROKES);
            default: ;
        endcase
    end

    // Next-state logic; abort overrides everything and suppresses done.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE:    if (start)       state_d = ST_FILL;
            ST_FILL:    if (cyc_last)    state_d = ST_LYSE;
            ST_LYSE:    if (stroke_done) state_d = ST_MIX;
            ST_MIX:     if (stroke_done) state_d = ST_TRAP;
            ST_TRAP:    if (cyc_last)    state_d = ST_WASH;
            ST_WASH:    if (stroke_done) state_d = ST_ELUTE;
            ST_ELUTE:   if (stroke_done) state_d = ST_COLLECT;
            ST_COLLECT: begin
                if (cyc_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
        cyc_d   = (timed && (state_d == state_q)) ? cyc_q + CYC_W'(1) : '0;
        valve_d = ~VALVE_OPEN[state_d];
        busy_d  = (state_d != ST_IDLE);
    end

    // State, timer and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            valve_q <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            valve_q <= valve_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    peristaltic_pump_drv #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .STROKE_W     (STROKE_W)
    ) u_pump (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (is_pumped(state_d)),
        .strokes     (strokes_sel),
        .pump        (pump_vec),
        .stroke_done (stroke_done)
    );

    assign lysis_ctl      = valve_q[V_LYSIS];
    assign wash_ctl       = valve_q[V_WASH];
    assign elute_ctl      = valve_q[V_ELUTE];
    assign horiz_ctl      = valve_q[V_HORIZ];
    assign vertical_ctl   = valve_q[V_VERTICAL];
    assign dead_end_ctl   = valve_q[V_DEAD_END];
    assign loop_exit_ctl  = valve_q[V_LOOP_EXIT];
    assign bead_vtl_ctl   = valve_q[V_BEAD_VTL];
    assign bead_trap_ctl  = valve_q[V_BEAD_TRAP];
    assign collection_ctl = valve_q[V_COLLECTION];
    assign pump1          = pump_vec[2];
    assign pump2          = pump_vec[1];
    assign pump3          = pump_vec[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign state          = state_q;

endmodule

// File: tb/tb_nucleic_acid_ctrl.sv
// Bench for nucleic_acid_ctrl: run-time model plus directed literal checks.
// Latency: outputs sampled on the falling edge, one half cycle after each update.
// Backpressure: n/a.
module tb_nucleic_acid_ctrl;

    localparam int PC = 2, FC = 3, LS = 1, MS = 2, WS = 1, ES = 1, CC = 2;
    localparam int TOTAL = 2 * FC + CC + 6 * PC * (LS + MS + WS + ES);
    localparam logic [9:0] ALL1 = 10'h3FF;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl;
    logic loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl;
    logic pump1, pump2, pump3, busy, done;
    logic [2:0] state;
    logic [9:0] vlv;
    logic [2:0] pmp;

    always #5 clk = ~clk;

    nucleic_acid_ctrl #(
        .PHASE_CYCLES(PC), .FILL_CYCLES(FC), .LYSE_STROKES(LS), .MIX_STROKES(MS),
        .WASH_STROKES(WS), .ELUTE_STROKES(ES), .COLLECT_CYCLES(CC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
        .horiz_ctl(horiz_ctl), .vertical_ctl(vertical_ctl), .dead_end_ctl(dead_end_ctl),
        .loop_exit_ctl(loop_exit_ctl), .bead_vtl_ctl(bead_vtl_ctl),
        .bead_trap_ctl(bead_trap_ctl), .collection_ctl(collection_ctl),
        .pump1(pump1), .pump2(pump2), .pump3(pump3),
        .busy(busy), .done(done), .state(state)
    );

    // Bench's own valve ordering: lysis down to collection.
    assign vlv = {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl,
                  loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl};
    assign pmp = {pump1, pump2, pump3};

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;

    // ---------------- run-time model ----------------
    bit m_active = 1'b0, m_done = 1'b0;
    int m_t = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_t <= 0; m_done <= 1'b0;
        end else if (m_active) begin
            if (abort) begin
                m_active <= 1'b0; m_done <= 1'b0;
            end else if (m_t + 1 == TOTAL) begin
                m_active <= 1'b0; m_done <= 1'b1; m_t <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end else begin
            m_done <= 1'b0;
            if (start && !abort) begin
                m_active <= 1'b1; m_t <= 0;
            end
        end
    end

    function automatic int seg_len(int i);
        case (i)
            0: return FC;
            1: return 6 * PC * LS;
            2: return 6 * PC * MS;
            3: return FC;
            4: return 6 * PC * WS;
            5: return 6 * PC * ES;
            default: return CC;
        endcase
    endfunction

    function automatic logic [2:0] pat(int ph);
        case (ph)
            0: return 3'b011;
            1: return 3'b001;
            2: return 3'b101;
            3: return 3'b100;
            4: return 3'b110;
            default: return 3'b010;
        endcase
    endfunction

    // Expected state and pump given time since run start.
    task automatic model_exp(input int t, output logic [2:0] st, output logic [2:0] pp);
        int base;
        base = 0; st = 3'd0; pp = 3'b111;
        for (int i = 0; i < 7; i++) begin
            if (st == 3'd0 && t < base + seg_len(i)) begin
                st = 3'(i + 1);
                if (i == 1 || i == 2 || i == 4 || i == 5) pp = pat(((t - base) / PC) % 6);
            end
            base += seg_len(i);
        end
    endtask

    function automatic logic [9:0] exp_vlv(logic [2:0] st);
        logic [9:0] v;
        v = ALL1;
        case (st)
            3'd1: v[6] = 1'b0;
            3'd2: begin v[9] = 1'b0; v[5] = 1'b0; end
            3'd4: begin v[3] = 1'b0; v[2] = 1'b0; v[8] = 1'b0; end
            3'd5: begin v[8] = 1'b0; v[5] = 1'b0; end
            3'd6: begin v[7] = 1'b0; v[5] = 1'b0; end
            3'd7: begin v[3] = 1'b0; v[1] = 1'b0; v[0] = 1'b0; end
            default: ;
        endcase
        return v;
    endfunction

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        logic [2:0] es, ep;
        logic [4:0] ectl, gctl;
        if (chk_en) begin
            if (m_active) model_exp(m_t, es, ep);
            else begin es = 3'd0; ep = 3'b111; end
            ectl = {es, m_active, m_done && !m_active};
            gctl = {state, busy, done};
            n_tests++;
            if (gctl !== ectl) begin
                n_fail++;
                $display("FAIL model_ctrl t=%0t: {state,busy,done} got %b expected %b", $time, gctl, ectl);
            end
            n_tests++;
            if (pmp !== ep) begin
                n_fail++;
                $display("FAIL model_pump t=%0t: got %b expected %b", $time, pmp, ep);
            end
            n_tests++;
            if (vlv !== exp_vlv(es)) begin
                n_fail++;
                $display("FAIL model_valves t=%0t: got %b expected %b", $time, vlv, exp_vlv(es));
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [2:0] st_log [0:79];
    logic [2:0] pp_log [0:79];
    logic [9:0] vl_log [0:79];
    logic       dn_log [0:79];
    logic       bz_log [0:79];

    // Pulse start, then log 80 cycles; optionally re-pulse start at cycle extra_c.
    task automatic run_capture(input int extra_c);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            st_log[c] = state; pp_log[c] = pmp; vl_log[c] = vlv;
            dn_log[c] = done;  bz_log[c] = busy;
            start = (c == extra_c);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic check_sequence(input string tag);
        int bnd [8];
        int ndone;
        bnd = '{0, 3, 15, 39, 42, 54, 66, 68};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_state_at_%0d", tag, bnd[i]), 32'(st_log[bnd[i]]), 32'((i + 1) % 8));
            if (i > 0)
                chk($sformatf("%s_state_before_%0d", tag, bnd[i]), 32'(st_log[bnd[i] - 1]), 32'(i));
        end
        ndone = 0;
        for (int c = 0; c < 80; c++) ndone += int'(dn_log[c]);
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_done_at_68"}, 32'(dn_log[68]), 32'd1);
        chk({tag, "_busy_at_0"}, 32'(bz_log[0]), 32'd1);
        chk({tag, "_busy_at_67"}, 32'(bz_log[67]), 32'd1);
        chk({tag, "_busy_at_68"}, 32'(bz_log[68]), 32'd0);
    endtask

    initial begin
        logic [2:0] lyse_exp [12];
        int dead_zero, ndone;
        lyse_exp = '{3'b011, 3'b011, 3'b001, 3'b001, 3'b101, 3'b101,
                     3'b100, 3'b100, 3'b110, 3'b110, 3'b010, 3'b010};

        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_valves", 32'(vlv), 32'(ALL1));
        chk("reset_pumps", 32'(pmp), 32'(3'b111));
        chk("reset_busy_done", 32'({busy, done}), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // Full run
        run_capture(-1);
        check_sequence("full");
        for (int k = 0; k < 12; k++)
            chk($sformatf("lyse_pump_%0d", k), 32'(pp_log[3 + k]), 32'(lyse_exp[k]));
        chk("mix_entry_pump", 32'(pp_log[15]), 32'(3'b011));
        chk("trap_pump", 32'(pp_log[40]), 32'(3'b111));
        chk("fill_valves", 32'(vl_log[1]), 32'(10'b1110111111));
        chk("wash_valves", 32'(vl_log[48]), 32'(10'b1011011111));
        chk("collect_valves", 32'(vl_log[67]), 32'(10'b1111110100));
        dead_zero = 0;
        for (int c = 0; c < 80; c++) if (vl_log[c][4] !== 1'b1) dead_zero++;
        chk("dead_end_always_1", 32'(dead_zero), 32'd0);

        // Start ignored while running
        run_capture(5);
        check_sequence("ign");

        // Synchronous reset mid-LYSE
        start = 1'b1; tick(); start = 1'b0;
        ticks(5);
        chk("pre_reset_lyse", 32'(state), 32'd2);
        rst_n = 1'b0;
        tick();
        chk("rst1_state", 32'(state), 32'd0);
        chk("rst1_valves", 32'(vlv), 32'(ALL1));
        chk("rst1_pumps", 32'(pmp), 32'(3'b111));
        chk("rst1_busy_done", 32'({busy, done}), 32'd0);
        tick();
        chk("rst2_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        ticks(3);

        // Abort during MIX
        start = 1'b1; tick(); start = 1'b0;
        ticks(20);
        chk("pre_abort_mix", 32'(state), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_valves", 32'(vlv), 32'(ALL1));
        chk("abort_pumps", 32'(pmp), 32'(3'b111));
        chk("abort_busy_done", 32'({busy, done}), 32'd0);
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            ndone += int'(done);
            tick();
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_state", 32'(state), 32'd0);
        chk("start_abort_busy", 32'(busy), 32'd0);
        ticks(2);
        chk("start_abort_stays", 32'(state), 32'd0);

        // Held start relaunches on the done cycle
        start = 1'b1;
        tick();
        ticks(68);
        chk("held_done_state", 32'(state), 32'd0);
        chk("held_done_pulse", 32'(done), 32'd1);
        tick();
        start = 1'b0;
        chk("held_relaunch_state", 32'(state), 32'd1);
        chk("held_relaunch_busy", 32'(busy), 32'd1);
        chk("held_relaunch_horiz", 32'(horiz_ctl), 32'd0);
        ticks(TOTAL + 3);
        chk("held_final_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
